// File: rtl/fp_pkg.sv
// Shared floating-point definitions for the FP datapath.
//   fp32_t  : IEEE-754 single-precision field layout
//   FP_ZERO : positive zero encoding
//   FP_BIAS : single-precision exponent bias
package fp_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] man;
  } fp32_t;

  localparam logic [31:0] FP_ZERO = 32'h0000_0000;
  localparam int          FP_BIAS = 127;

  // Assemble a single-precision word from its fields.
  function automatic fp32_t fp_pack(input logic sign, input logic [7:0] exp,
                                    input logic [22:0] man);
    fp32_t f;
    f.sign = sign;
    f.exp  = exp;
    f.man  = man;
    return f;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter.
//   req    : per-requester request vector
//   en     : arbitration enable; gnt is forced to 0 when low
//   ptr    : index with the highest priority this cycle
//   gnt    : one-hot grant (0 when disabled or no request)
//   winner : encoded index of the first set req bit at or after ptr
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic          en,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] winner
);

  logic found_s;

  // Scan requesters starting at ptr and wrapping; the first set bit wins.
  always_comb begin
    int idx;
    gnt     = '0;
    winner  = '0;
    found_s = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx     = (int'(ptr) + k) % N;
      winner  = (!found_s && req[idx]) ? IW'(idx) : winner;
      found_s = found_s | req[idx];
    end
    if (en && found_s) begin
      gnt[winner] = 1'b1;
    end else begin
      gnt = '0;
    end
  end

endmodule

// File: rtl/signed_int_to_float.sv
// Combinational signed 32-bit integer to IEEE-754 single conversion.
// Rounds to nearest, ties to even (only magnitudes above 2^24 can round).
//   int_in : two's-complement operand
//   fp_out : single-precision result; zero maps to +0.0
module signed_int_to_float
  import fp_pkg::*;
(
  input  logic [31:0] int_in,
  output logic [31:0] fp_out
);

  logic        sign_s;
  logic [31:0] mag_s;
  logic [4:0]  msb_s;
  logic [31:0] norm_s;
  logic        guard_s;
  logic        sticky_s;
  logic        round_up_s;
  logic [23:0] man_rnd_s;
  logic [7:0]  exp_s;
  fp32_t       res_s;

  // Magnitude, leading-one search, normalisation and rounding.
  always_comb begin
    sign_s = int_in[31];
    // -2^31 negates to 0x8000_0000, which is the correct unsigned magnitude.
    mag_s  = sign_s ? (32'd0 - int_in) : int_in;
    msb_s  = 5'd0;
    for (int i = 0; i < 32; i++) begin
      msb_s = mag_s[i] ? 5'(i) : msb_s;
    end
    // After the shift the hidden one sits in bit 31 (bit 31 stays 0 only for a zero input).
    norm_s     = mag_s << (5'd31 - msb_s);
    guard_s    = norm_s[7];
    sticky_s   = |norm_s[6:0];
    round_up_s = guard_s & (sticky_s | norm_s[8]);
    man_rnd_s  = {1'b0, norm_s[30:8]} + {23'd0, round_up_s};
    // A mantissa carry-out bumps the exponent; the mantissa bits are then already 0.
    exp_s      = 8'(FP_BIAS) + {3'd0, msb_s} + {7'd0, man_rnd_s[23]};
    if (norm_s[31]) begin
      res_s = fp_pack(sign_s, exp_s, man_rnd_s[22:0]);
    end else begin
      res_s = FP_ZERO;
    end
  end

  assign fp_out = res_s;

endmodule

// File: rtl/int2fp_arbiter.sv
// Shares one integer-to-float converter among NUM_REQ requesters.
// Round-robin grant into an operand register (stage 1), conversion, then a
// result register (stage 2) with a valid/ready output handshake.
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : per-requester request, held with its operand until granted
//   int_in     : packed signed operands, requester i at [32*i+31:32*i]
//   gnt        : combinational one-hot acceptance of an operand this cycle
//   fp_out     : registered single-precision result
//   fp_id      : requester index of fp_out
//   fp_vld     : result valid
//   fp_rdy     : downstream accepts the result
//   busy       : some pipeline stage holds data
//   conv_cnt   : results delivered since reset (wraps)
module int2fp_arbiter
  import fp_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [32*NUM_REQ-1:0] int_in,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [31:0]          fp_out,
  output logic [ID_W-1:0]      fp_id,
  output logic                 fp_vld,
  input  logic                 fp_rdy,
  output logic                 busy,
  output logic [15:0]          conv_cnt
);

  // Stage 1: operand register
  logic            op_vld_q, op_vld_d;
  logic [31:0]     op_val_q, op_val_d;
  logic [ID_W-1:0] op_id_q,  op_id_d;
  logic [ID_W-1:0] ptr_q,    ptr_d;

  // Stage 2: result register
  logic            fp_vld_q, fp_vld_d;
  logic [31:0]     fp_out_q, fp_out_d;
  logic [ID_W-1:0] fp_id_q,  fp_id_d;

  logic [15:0]     conv_cnt_q, conv_cnt_d;
  logic            busy_q,     busy_d;

  logic               adv1_s;
  logic               adv2_s;
  logic               arb_en_s;
  logic [NUM_REQ-1:0] gnt_s;
  logic [ID_W-1:0]    win_s;
  logic [31:0]        conv_s;

  // Arbitration is only meaningful when stage 1 can take an operand; the
  // reset term keeps gnt low while the pipeline is held in reset.
  assign adv2_s   = !fp_vld_q | fp_rdy;
  assign adv1_s   = !op_vld_q | adv2_s;
  assign arb_en_s = adv1_s & rst_n;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (ID_W)
  ) u_arb (
    .req    (req),
    .en     (arb_en_s),
    .ptr    (ptr_q),
    .gnt    (gnt_s),
    .winner (win_s)
  );

  signed_int_to_float u_conv (
    .int_in (op_val_q),
    .fp_out (conv_s)
  );

  // Stage 1 next state: load the winner, drain when idle, hold when stalled.
  always_comb begin
    op_vld_d = op_vld_q;
    op_val_d = op_val_q;
    op_id_d  = op_id_q;
    ptr_d    = ptr_q;
    if (adv1_s) begin
      if (|gnt_s) begin
        op_vld_d = 1'b1;
        op_val_d = int_in[32*int'(win_s) +: 32];
        op_id_d  = win_s;
        // Priority moves just past the winner so it cannot win twice in a row
        // while others are waiting.
        if (win_s == ID_W'(NUM_REQ - 1)) begin
          ptr_d = '0;
        end else begin
          ptr_d = win_s + ID_W'(1);
        end
      end else begin
        op_vld_d = 1'b0;
      end
    end else begin
      op_vld_d = op_vld_q;
    end
  end

  // Stage 2 next state, delivery counter and occupancy flag.
  always_comb begin
    fp_vld_d = fp_vld_q;
    fp_out_d = fp_out_q;
    fp_id_d  = fp_id_q;
    if (adv2_s) begin
      if (op_vld_q) begin
        fp_vld_d = 1'b1;
        fp_out_d = conv_s;
        fp_id_d  = op_id_q;
      end else begin
        fp_vld_d = 1'b0;
      end
    end else begin
      fp_vld_d = fp_vld_q;
    end
    if (fp_vld_q && fp_rdy) begin
      conv_cnt_d = conv_cnt_q + 16'd1;
    end else begin
      conv_cnt_d = conv_cnt_q;
    end
    busy_d = op_vld_d | fp_vld_d;
  end

  // Pipeline, pointer and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_vld_q   <= 1'b0;
      op_val_q   <= 32'd0;
      op_id_q    <= '0;
      ptr_q      <= '0;
      fp_vld_q   <= 1'b0;
      fp_out_q   <= FP_ZERO;
      fp_id_q    <= '0;
      conv_cnt_q <= 16'd0;
      busy_q     <= 1'b0;
    end else begin
      op_vld_q   <= op_vld_d;
      op_val_q   <= op_val_d;
      op_id_q    <= op_id_d;
      ptr_q      <= ptr_d;
      fp_vld_q   <= fp_vld_d;
      fp_out_q   <= fp_out_d;
      fp_id_q    <= fp_id_d;
      conv_cnt_q <= conv_cnt_d;
      busy_q     <= busy_d;
    end
  end

  assign gnt      = gnt_s;
  assign fp_out   = fp_out_q;
  assign fp_id    = fp_id_q;
  assign fp_vld   = fp_vld_q;
  assign busy     = busy_q;
  assign conv_cnt = conv_cnt_q;

endmodule

// File: tb/tb_int2fp_arbiter.sv
module tb_int2fp_arbiter;

  localparam int N  = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [32*N-1:0] int_in;
  logic [N-1:0]    gnt;
  logic [31:0]     fp_out;
  logic [IW-1:0]   fp_id;
  logic            fp_vld;
  logic            fp_rdy;
  logic            busy;
  logic [15:0]     conv_cnt;

  int2fp_arbiter #(.NUM_REQ(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .int_in   (int_in),
    .gnt      (gnt),
    .fp_out   (fp_out),
    .fp_id    (fp_id),
    .fp_vld   (fp_vld),
    .fp_rdy   (fp_rdy),
    .busy     (busy),
    .conv_cnt (conv_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [31:0]   fp;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, want);
    end
  endtask

  task automatic push(input int id, input logic [31:0] fp);
    exp_t e;
    e.id = IW'(id);
    e.fp = fp;
    sb_q.push_back(e);
  endtask

  // drive point: just after the rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // sample point: falling edge
  task automatic smp();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drain(input string nm);
    int t;
    t = 0;
    while ((sb_q.size() != 0 || busy) && t < 100) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (t >= 100) begin
      n_fail++;
      $display("FAIL %s_drain: %0d results outstanding, expected 0 within 100 cycles",
               nm, sb_q.size());
    end
  endtask

  // Monitor: every accepted result must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && fp_vld && fp_rdy) begin
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_result: got id=%0d fp=%h, expected no result", fp_id, fp_out);
      end else begin
        e = sb_q.pop_front();
        if (fp_out !== e.fp || fp_id !== e.id) begin
          n_fail++;
          $display("FAIL result: got id=%0d fp=%h, expected id=%0d fp=%h",
                   fp_id, fp_out, e.id, e.fp);
        end
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rr_exp [4];
    logic [N-1:0] oh;
    int cnt;
    int it;
    rr_exp[0] = 32'h42C8_0000;  // 100
    rr_exp[1] = 32'hC000_0000;  // -2
    rr_exp[2] = 32'h0000_0000;  // 0
    rr_exp[3] = 32'hBF80_0000;  // -1

    // ---- reset state (requests asserted, no grant allowed) ----
    rst_n  = 1'b0;
    req    = 4'b1111;
    int_in = '0;
    fp_rdy = 1'b1;
    smp();
    chk("rst_gnt",  32'(gnt), 32'd0);
    chk("rst_vld",  32'(fp_vld), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cnt",  32'(conv_cnt), 32'd0);
    chk("rst_out",  fp_out, 32'd0);
    chk("rst_id",   32'(fp_id), 32'd0);
    req = 4'b0000;
    do_reset();

    // ---- single request, latency 2 ----
    cyc();
    req = 4'b0001;
    int_in[31:0] = 32'd1;
    smp();
    chk("single_gnt", 32'(gnt), 32'd1);
    push(0, 32'h3F80_0000);
    chk("single_vld_n", 32'(fp_vld), 32'd0);
    cyc();
    req = 4'b0000;
    smp();
    chk("single_gnt_off", 32'(gnt), 32'd0);
    chk("single_vld_n1", 32'(fp_vld), 32'd0);
    cyc();
    smp();
    chk("single_vld_n2", 32'(fp_vld), 32'd1);
    drain("single");
    chk("single_cnt", 32'(conv_cnt), 32'd1);

    // ---- round robin over four requesters ----
    do_reset();
    cyc();
    req = 4'b1111;
    int_in = {32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFE, 32'd100};
    for (int k = 0; k < 8; k++) begin
      if (k > 0) cyc();
      smp();
      oh = '0;
      oh[k % 4] = 1'b1;
      chk("rr_gnt", 32'(gnt), 32'(oh));
      push(k % 4, rr_exp[k % 4]);
      if (k >= 2) chk("rr_stream_vld", 32'(fp_vld), 32'd1);
    end
    cyc();
    req = 4'b0000;
    smp();
    chk("rr_gnt_off", 32'(gnt), 32'd0);
    drain("rr");
    chk("rr_cnt", 32'(conv_cnt), 32'd8);

    // ---- backpressure ----
    do_reset();
    cyc();
    fp_rdy = 1'b0;
    req = 4'b0011;
    int_in[31:0]  = 32'd7;
    int_in[63:32] = 32'hFFFF_FFFD;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) cyc();
      smp();
      oh = '0;
      if (k == 0) oh = 4'b0001;
      if (k == 1) oh = 4'b0010;
      chk("bp_gnt", 32'(gnt), 32'(oh));
      if (k == 0) push(0, 32'h40E0_0000);
      if (k == 1) push(1, 32'hC040_0000);
      if (k >= 2) begin
        chk("bp_vld_hold", 32'(fp_vld), 32'd1);
        chk("bp_out_hold", fp_out, 32'h40E0_0000);
        chk("bp_id_hold",  32'(fp_id), 32'd0);
      end
    end
    cyc();
    fp_rdy = 1'b1;
    req = 4'b0000;
    drain("bp");
    chk("bp_cnt", 32'(conv_cnt), 32'd2);

    // ---- pointer fairness ----
    do_reset();
    cyc();
    req = 4'b0101;
    int_in[31:0]  = 32'd5;
    int_in[95:64] = 32'hFFFF_FFF9;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) cyc();
      smp();
      oh = (k % 2 == 0) ? 4'b0001 : 4'b0100;
      chk("fair_gnt", 32'(gnt), 32'(oh));
      if (k % 2 == 0) push(0, 32'h40A0_0000);
      else            push(2, 32'hC0E0_0000);
    end
    cyc();
    req = 4'b0000;
    drain("fair");
    chk("fair_cnt", 32'(conv_cnt), 32'd4);

    // ---- reset mid-operation (results in flight are discarded) ----
    cyc();
    fp_rdy = 1'b0;
    req = 4'b0011;
    int_in[31:0]  = 32'd1;
    int_in[63:32] = 32'd2;
    cyc();
    cyc();
    req = 4'b0000;
    smp();
    chk("mid_full_busy", 32'(busy), 32'd1);
    chk("mid_full_vld",  32'(fp_vld), 32'd1);
    chk("mid_full_gnt",  32'(gnt), 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vld",  32'(fp_vld), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_cnt",  32'(conv_cnt), 32'd0);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    fp_rdy = 1'b1;
    req = 4'b0110;
    int_in[63:32] = 32'd2;
    int_in[95:64] = 32'd3;
    smp();
    chk("mid_first_gnt", 32'(gnt), 32'b0010);
    push(1, 32'h4000_0000);
    cyc();
    req = 4'b0000;
    drain("mid");
    chk("mid_cnt", 32'(conv_cnt), 32'd1);

    // ---- counter wrap after 65537 transfers ----
    do_reset();
    cyc();
    req = 4'b0001;
    int_in[31:0] = 32'hFFFF_FFFF;
    cnt = 0;
    it  = 0;
    while (cnt < 65537 && it < 70000) begin
      smp();
      if (gnt[0]) begin
        push(0, 32'hBF80_0000);
        cnt++;
      end
      it++;
      if (cnt < 65537) cyc();
    end
    cyc();
    req = 4'b0000;
    chk("wrap_grants", 32'(cnt), 32'd65537);
    drain("wrap");
    chk("wrap_cnt", 32'(conv_cnt), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
